// File: rtl/shift_subtractor.sv
// -----------------------------------------------------------------------------
// shift_subtractor
//   Fully pipelined restoring shift-subtract divider for unsigned operands.
//   WIDTH register stages each resolve one quotient bit, MSB first, so a new
//   operation can enter on every clock and its result appears WIDTH-1 edges
//   after the edge that sampled it.
//
// Parameters
//   LOG2_WIDTH : log2 of the operand width (WIDTH = 2**LOG2_WIDTH)
//
// Ports
//   clk        : clock, all flops rise-edge triggered
//   rst_n      : asynchronous active-low reset, clears the whole pipeline
//   dividend   : unsigned dividend, sampled every rising edge
//   divisor    : unsigned divisor, sampled every rising edge
//   din_valid  : operands valid this cycle
//   quotient   : unsigned quotient from the final stage
//   remainder  : unsigned remainder from the final stage
//   dout_valid : quotient/remainder valid this cycle
//   div_zero   : result came from a zero divisor
//                (only with SHIFT_SUBTRACTOR_DIV_ZERO_EN defined)
//
// Configuration macro
//   SHIFT_SUBTRACTOR_DIV_ZERO_EN : adds the div_zero port and its pipeline.
// -----------------------------------------------------------------------------
module shift_subtractor #(
  parameter  int LOG2_WIDTH = 2,
  localparam int WIDTH      = 2 ** LOG2_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             din_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dout_valid
`ifdef SHIFT_SUBTRACTOR_DIV_ZERO_EN
  ,
  output logic             div_zero
`endif
);

  // Per-stage state. Stage k holds the result of resolving quotient bit
  // WIDTH-1-k. The divisor and dividend only need to travel as far as the
  // last stage that still consumes them, so their arrays stop one short.
  logic [WIDTH-1:0] r_rem [WIDTH];
  logic [WIDTH-1:0] r_quo [WIDTH];
  logic [WIDTH-1:0] r_dvd [WIDTH-1];
  logic [WIDTH-1:0] r_dvs [WIDTH-1];
  logic [WIDTH-1:0] r_valid;

  // Next-state values produced by each stage's combinational slice.
  logic [WIDTH-1:0] w_rem_next [WIDTH];
  logic [WIDTH-1:0] w_quo_next [WIDTH];

  for (genvar k = 0; k < WIDTH; k++) begin : g_stage
    logic [WIDTH-1:0] w_rem_in;
    logic [WIDTH-1:0] w_quo_in;
    logic [WIDTH-1:0] w_dvs_in;
    logic             w_dvd_bit;
    logic [WIDTH:0]   w_partial;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;

    if (k == 0) begin : g_head
      assign w_rem_in  = '0;
      assign w_quo_in  = '0;
      assign w_dvs_in  = divisor;
      assign w_dvd_bit = dividend[WIDTH-1];
    end else begin : g_body
      assign w_rem_in  = r_rem[k-1];
      assign w_quo_in  = r_quo[k-1];
      assign w_dvs_in  = r_dvs[k-1];
      assign w_dvd_bit = r_dvd[k-1][WIDTH-1-k];
    end

    // The partial remainder is one bit wider than the operands so the
    // subtraction cannot wrap into the data bits; its MSB is then a pure
    // borrow flag, and "no borrow" is exactly partial >= divisor.
    assign w_partial = {w_rem_in, w_dvd_bit};
    assign w_diff    = w_partial - {1'b0, w_dvs_in};
    assign w_qbit    = ~w_diff[WIDTH];

    // A kept remainder is always below the divisor (or, for a zero divisor,
    // a prefix of the dividend), so dropping the top bit loses nothing.
    assign w_rem_next[k] = w_qbit ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
    assign w_quo_next[k] = w_quo_in | (WIDTH'(w_qbit) << (WIDTH-1-k));
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's value from before the edge, not after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data arrays are reset too, not just the valid bits, so
      // outputs read zero during reset and nothing stale survives release.
      for (int k = 0; k < WIDTH; k++) begin
        r_rem[k] <= '0;
        r_quo[k] <= '0;
      end
      for (int k = 0; k < WIDTH-1; k++) begin
        r_dvd[k] <= '0;
        r_dvs[k] <= '0;
      end
      r_valid <= '0;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        r_rem[k] <= w_rem_next[k];
        r_quo[k] <= w_quo_next[k];
      end
      r_dvd[0] <= dividend;
      r_dvs[0] <= divisor;
      for (int k = 1; k < WIDTH-1; k++) begin
        r_dvd[k] <= r_dvd[k-1];
        r_dvs[k] <= r_dvs[k-1];
      end
      r_valid <= {r_valid[WIDTH-2:0], din_valid};
    end
  end

  assign quotient   = r_quo[WIDTH-1];
  assign remainder  = r_rem[WIDTH-1];
  assign dout_valid = r_valid[WIDTH-1];

`ifdef SHIFT_SUBTRACTOR_DIV_ZERO_EN
  // Zero-divisor flag travels alongside the valid bit.
  logic [WIDTH-1:0] r_dz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dz <= '0;
    end else begin
      r_dz <= {r_dz[WIDTH-2:0], (divisor == '0)};
    end
  end

  assign div_zero = r_dz[WIDTH-1];
`endif

endmodule

// File: tb/tb_shift_subtractor.sv
module tb_shift_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         din_valid = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dout_valid;
  logic         div_zero;

  int total = 0;
  int bad   = 0;

  shift_subtractor #(.LOG2_WIDTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dividend  (dividend),
    .divisor   (divisor),
    .din_valid (din_valid),
    .quotient  (quotient),
    .remainder (remainder),
`ifdef SHIFT_SUBTRACTOR_DIV_ZERO_EN
    .div_zero  (div_zero),
`endif
    .dout_valid(dout_valid)
  );

`ifndef SHIFT_SUBTRACTOR_DIV_ZERO_EN
  assign div_zero = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic         v;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Reference division straight from the arithmetic definition.
  function automatic exp_t ref_div(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.v = v;
    if (b == 0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Model: every edge out of reset samples the operands; the result of the
  // sample taken W-1 edges ago is what the outputs must show now.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      exp_q.push_back(ref_div(din_valid, dividend, divisor));
      if (exp_q.size() > W) void'(exp_q.pop_front());
    end
  end

  // Continuous compare, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_quotient", 32'(quotient), 0);
      check("rst_remainder", 32'(remainder), 0);
      check("rst_dout_valid", 32'(dout_valid), 0);
      check("rst_div_zero", 32'(div_zero), 0);
    end else if (exp_q.size() == W) begin
      check("dout_valid", 32'(dout_valid), 32'(exp_q[0].v));
      if (exp_q[0].v) begin
        check("quotient", 32'(quotient), 32'(exp_q[0].q));
        check("remainder", 32'(remainder), 32'(exp_q[0].r));
`ifdef SHIFT_SUBTRACTOR_DIV_ZERO_EN
        check("div_zero", 32'(div_zero), 32'(exp_q[0].dz));
`endif
      end
    end else begin
      check("fill_dout_valid", 32'(dout_valid), 0);
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic v);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    din_valid = v;
  endtask

  // Single operation with hand-computed expectations, checked W-1 edges
  // after the sampling edge.
  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    exp_t e;
    e = ref_div(1'b1, a, b);
    check({name, "_model_q"}, 32'(e.q), 32'(eq));
    check({name, "_model_r"}, 32'(e.r), 32'(er));
    drive(a, b, 1'b1);
    @(posedge clk);
    #1 din_valid = 1'b0;
    repeat (W-1) @(posedge clk);
    #1;
    check({name, "_q"}, 32'(quotient), 32'(eq));
    check({name, "_r"}, 32'(remainder), 32'(er));
    check({name, "_dv"}, 32'(dout_valid), 1);
`ifdef SHIFT_SUBTRACTOR_DIV_ZERO_EN
    check({name, "_dz"}, 32'(div_zero), 32'(edz));
`else
    if (edz) check({name, "_dz_absent"}, 32'(div_zero), 0);
`endif
  endtask

  initial begin
    #2;
    check("init_quotient", 32'(quotient), 0);
    check("init_dout_valid", 32'(dout_valid), 0);
    #21 rst_n = 1'b1;

    directed("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    directed("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    directed("d2_5", 4'd2, 4'd5, 4'd0, 4'd2, 1'b0);
    directed("d7_0", 4'd7, 4'd0, 4'd15, 4'd7, 1'b1);

    // Back-to-back random operands, valid every cycle.
    for (int i = 0; i < 100; i++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
    end
    drive(4'd0, 4'd0, 1'b0);
    repeat (W + 1) @(posedge clk);

    // Valid pattern 1,0,1 must reappear as 1,0,1.
    drive(4'd9, 4'd2, 1'b1);
    drive(4'd0, 4'd0, 1'b0);
    drive(4'd11, 4'd4, 1'b1);
    @(posedge clk);
    #1 din_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pat_dv0", 32'(dout_valid), 1);
    check("pat_q0", 32'(quotient), 4);
    check("pat_r0", 32'(remainder), 1);
    @(posedge clk);
    #1;
    check("pat_dv1", 32'(dout_valid), 0);
    @(posedge clk);
    #1;
    check("pat_dv2", 32'(dout_valid), 1);
    check("pat_q2", 32'(quotient), 2);
    check("pat_r2", 32'(remainder), 3);

    // Reset with two operations in flight.
    drive(4'd12, 4'd5, 1'b1);
    drive(4'd14, 4'd3, 1'b1);
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    #1;
    check("midrst_quotient", 32'(quotient), 0);
    check("midrst_remainder", 32'(remainder), 0);
    check("midrst_dout_valid", 32'(dout_valid), 0);
    check("midrst_div_zero", 32'(div_zero), 0);
    #9 rst_n = 1'b1;
    for (int i = 0; i < W + 1; i++) begin
      @(posedge clk);
      #1 check("postrst_dv", 32'(dout_valid), 0);
    end
    directed("d6_4", 4'd6, 4'd4, 4'd1, 4'd2, 1'b0);

    repeat (W + 2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
